mmio_pwm: RTL and testbench
===========================

MMIO_PWM -- requirements
Module: mmio_pwm

Interface
REQ-001 Parameter BASE_ADDR, 32'hFFFF_F100, word-aligned base of the 8-word register window.
REQ-002 Parameter CH, 4, number of PWM channels (fixed at 4 for this revision).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 write_mem  input  1  bus write strobe from the CPU.
REQ-006 write_address  input  32  byte address of the write.
REQ-007 write_data  input  32  write data.
REQ-008 read_address  input  32  byte address of the read.
REQ-009 read_data  output  32  registered read data.
REQ-010 pwm_out  output  4  PWM waveforms, one bit per channel.

Function
REQ-011 Decode: an access hits when address[31:5]==BASE_ADDR[31:5]; offset = address[4:2]; address[1:0] ignored; only full-word access is supported.
REQ-012 Register map offsets: 0 CTRL (bit0 EN, bits[15:8] PRESC), 1 PERIOD[15:0], 2-5 DUTY0-DUTY3[15:0], 6 COUNT (read-only), 7 STATUS (bit0 WRAP, write-1-to-clear).
REQ-013 Write: a hitting write_mem updates the addressed register at the clock edge; unused bits read 0; writes to COUNT or to non-hitting addresses have no effect.
REQ-014 Read: read_data shall present the register at read_address one cycle after read_address is sampled; a non-hitting address returns 32'h0.
REQ-015 Read-during-write to the same register returns the value before the write.
REQ-016 Prescaler: when EN=1, an 8-bit prescaler counts 0..PRESC and asserts a one-cycle tick as it wraps to 0; PRESC=0 gives a tick every cycle.
REQ-017 Counter: on each tick, the 16-bit COUNT increments; if COUNT equals active period, COUNT becomes 0 instead (period length = active period + 1 ticks).
REQ-018 Shadowing: active period and active duties shall load from PERIOD/DUTYn only on the tick where COUNT wraps to 0, and on the cycle EN transitions 0->1; mid-period writes do not affect the current period.
REQ-019 Output: pwm_out[n] = EN && (COUNT < active duty n), registered; duty 0 yields constant low, duty > active period yields constant high.
REQ-020 WRAP: set on every COUNT wrap; cleared by writing 1 to STATUS bit0; a clear coinciding with a wrap leaves WRAP=1 (set wins).
REQ-021 Disable: when EN=0, prescaler and COUNT are held at 0 and pwm_out = 4'b0000; register contents are retained.
REQ-022 PERIOD=0: COUNT stays 0 and each tick is a wrap; pwm_out[n]=1 iff active duty n != 0.

Reset
REQ-023 On reset, CTRL, PERIOD, DUTY0-3, active shadows, prescaler, COUNT, STATUS, read_data and pwm_out shall all be 0 at the next edge.
REQ-024 Reset asserted mid-period aborts the period immediately; no WRAP is set by the reset itself.
REQ-025 Reset has priority over any simultaneous bus write.

Verification
REQ-026 Write PERIOD=9, DUTY0=3, CTRL=0x0001 -> pwm_out[0] high 3 cycles, low 7, repeating every 10 cycles; WRAP sets after first 10.
REQ-027 CTRL=0x0301 (PRESC=3), PERIOD=4, DUTY1=2 -> COUNT advances every 4 cycles; pwm_out[1] high 8 cycles of each 20.
REQ-028 While running PERIOD=9/DUTY0=3, write DUTY0=7 at COUNT=5 -> current period unchanged, next period high 7 ticks.
REQ-029 DUTY2=0 and DUTY3=0xFFFF with PERIOD=9 -> pwm_out[2] constantly 0, pwm_out[3] constantly 1.
REQ-030 Write 1 to STATUS on the exact wrap cycle -> WRAP reads 1; write 1 mid-period -> WRAP reads 0.
REQ-031 Read BASE_ADDR+0x04 after PERIOD=9 -> read_data=32'h9 one cycle later; read BASE_ADDR+0x40 -> 32'h0; assert reset mid-run -> all outputs and COUNT 0 next cycle.

Source files
------------

// File: rtl/mmio_pwm.sv
// mmio_pwm: four-channel PWM generator behind an 8-word memory-mapped window.
//
// Register map (word offsets from BASE_ADDR):
//   0 CTRL   bit0 EN, bits[15:8] PRESC
//   1 PERIOD bits[15:0]
//   2-5      DUTY0..DUTY3 bits[15:0]
//   6 COUNT  read-only
//   7 STATUS bit0 WRAP, write 1 to clear
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   write_mem     bus write strobe
//   write_address byte address of the write
//   write_data    write data
//   read_address  byte address of the read
//   read_data     registered read data, one cycle after read_address
//   pwm_out       one PWM waveform per channel
module mmio_pwm #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F100,
  parameter int          CH        = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_mem,
  input  logic [31:0]   write_address,
  input  logic [31:0]   write_data,
  input  logic [31:0]   read_address,
  output logic [31:0]   read_data,
  output logic [CH-1:0] pwm_out
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PERIOD = 3'd1;
  localparam logic [2:0] OFF_DUTY0  = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd6;
  localparam logic [2:0] OFF_STATUS = 3'd7;

  // Programmed registers
  logic                en, en_d;
  logic [7:0]          presc, presc_d;
  logic [15:0]         period, period_d;
  logic [CH-1:0][15:0] duty, duty_d;
  logic                wrap, wrap_d;

  // Running state and shadows
  logic [7:0]          presc_cnt, presc_cnt_d;
  logic [15:0]         count, count_d;
  logic [15:0]         act_period, act_period_d;
  logic [CH-1:0][15:0] act_duty, act_duty_d;
  logic [CH-1:0]       pwm_d;
  logic [31:0]         rd_val;

  logic       wr_hit, rd_hit;
  logic [2:0] wr_off, rd_off;
  logic       run, tick, wrap_evt, load;

  assign wr_hit = write_mem && (write_address[31:5] == BASE_ADDR[31:5]);
  assign rd_hit = (read_address[31:5] == BASE_ADDR[31:5]);
  assign wr_off = write_address[4:2];
  assign rd_off = read_address[4:2];

  // Byte-lane bits and the upper data half carry no information here.
  logic unused_bits;
  assign unused_bits = ^{write_address[1:0], read_address[1:0], write_data[31:16]};

  always_comb begin
    // NOTE: every signal gets a default before any branch, otherwise a
    // path that skips an assignment infers a latch.
    en_d         = en;
    presc_d      = presc;
    period_d     = period;
    duty_d       = duty;
    wrap_d       = wrap;
    presc_cnt_d  = presc_cnt;
    count_d      = count;
    act_period_d = act_period;
    act_duty_d   = act_duty;
    pwm_d        = '0;

    if (wr_hit) begin
      case (wr_off)
        OFF_CTRL: begin
          en_d    = write_data[0];
          presc_d = write_data[15:8];
        end
        OFF_PERIOD: period_d = write_data[15:0];
        OFF_STATUS: if (write_data[0]) wrap_d = 1'b0;
        default: begin
          for (int n = 0; n < CH; n++)
            if (wr_off == 3'(OFF_DUTY0 + n)) duty_d[n] = write_data[15:0];
        end
      endcase
    end

    // The counters only advance while EN is set both before and after this
    // edge, so an enable or disable always leaves them parked at 0.
    run      = en && en_d;
    tick     = en && (presc_cnt == presc);
    wrap_evt = tick && (count == act_period);
    // Shadows follow the registers as they stood before this edge's write.
    load     = wrap_evt || (en_d && !en);

    if (!run)      presc_cnt_d = '0;
    else if (tick) presc_cnt_d = '0;
    else           presc_cnt_d = presc_cnt + 8'd1;

    if (!run)          count_d = '0;
    else if (wrap_evt) count_d = '0;
    else if (tick)     count_d = count + 16'd1;

    // Set wins over a coincident clear.
    if (wrap_evt) wrap_d = 1'b1;

    if (load) begin
      act_period_d = period;
      act_duty_d   = duty;
    end

    // Computed from next-state values so pwm_out always matches COUNT.
    for (int n = 0; n < CH; n++)
      pwm_d[n] = en_d && (count_d < act_duty_d[n]);
  end

  // Read mux sees pre-write register values, giving old data on a
  // same-cycle read of a register being written.
  always_comb begin
    rd_val = '0;
    if (rd_hit) begin
      case (rd_off)
        OFF_CTRL:   rd_val = {16'h0, presc, 7'h0, en};
        OFF_PERIOD: rd_val = {16'h0, period};
        OFF_COUNT:  rd_val = {16'h0, count};
        OFF_STATUS: rd_val = {31'h0, wrap};
        default: begin
          for (int n = 0; n < CH; n++)
            if (rd_off == 3'(OFF_DUTY0 + n)) rd_val = {16'h0, duty[n]};
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the duty/shadow arrays are a handful of flops, not a RAM, so
      // they are reset along with everything else.
      en         <= 1'b0;
      presc      <= '0;
      period     <= '0;
      duty       <= '0;
      wrap       <= 1'b0;
      presc_cnt  <= '0;
      count      <= '0;
      act_period <= '0;
      act_duty   <= '0;
      pwm_out    <= '0;
      read_data  <= '0;
    end else begin
      en         <= en_d;
      presc      <= presc_d;
      period     <= period_d;
      duty       <= duty_d;
      wrap       <= wrap_d;
      presc_cnt  <= presc_cnt_d;
      count      <= count_d;
      act_period <= act_period_d;
      act_duty   <= act_duty_d;
      pwm_out    <= pwm_d;
      read_data  <= rd_val;
    end
  end

endmodule

// File: tb/tb_mmio_pwm.sv
// Directed testbench for mmio_pwm. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when the DUT output is
// sampled on the falling clock edge.
module tb_mmio_pwm;

  localparam logic [31:0] BASE     = 32'hFFFF_F100;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_PERIOD = BASE + 32'h04;
  localparam logic [31:0] A_DUTY0  = BASE + 32'h08;
  localparam logic [31:0] A_DUTY1  = BASE + 32'h0C;
  localparam logic [31:0] A_DUTY2  = BASE + 32'h10;
  localparam logic [31:0] A_DUTY3  = BASE + 32'h14;
  localparam logic [31:0] A_COUNT  = BASE + 32'h18;
  localparam logic [31:0] A_STATUS = BASE + 32'h1C;

  logic        clk;
  logic        reset;
  logic        write_mem;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic [3:0]  pwm_out;

  mmio_pwm #(.BASE_ADDR(BASE), .CH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .write_mem     (write_mem),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  (read_address),
    .read_data     (read_data),
    .pwm_out       (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int t       = 0;   // falling edges since the last time-base reset

  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %0h but no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    write_mem     = 1'b1;
    write_address = a;
    write_data    = d;
    tick();
    write_mem     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    read_address = a;
    expect_val(exp);
    tick();
    check(tag, read_data);
  endtask

  function automatic logic [31:0] pv(input logic p3, input logic p2,
                                     input logic p1, input logic p0);
    return {28'h0, p3, p2, p1, p0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    write_mem     = 1'b0;
    write_address = '0;
    write_data    = '0;
    read_address  = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    expect_val(32'h0); check("rst_pwm", {28'h0, pwm_out});
    expect_val(32'h0); check("rst_rdata", read_data);
    rd(A_COUNT, "rst_count", 32'h0);
    rd(A_CTRL,  "rst_ctrl",  32'h0);

    // PERIOD=9, DUTY0=3: 3 high / 7 low, WRAP after the first 10 cycles
    wr(A_PERIOD, 32'd9);
    wr(A_DUTY0,  32'd3);
    wr(A_CTRL,   32'h1);
    t = 0;
    read_address = A_STATUS;
    expect_val(pv(0, 0, 0, 1'b1)); check("p9_pwm", {28'h0, pwm_out});
    for (int i = 1; i <= 20; i++) begin
      expect_val(pv(0, 0, 0, (i % 10) < 3));
      expect_val({31'h0, i >= 11});
      tick();
      check("p9_pwm", {28'h0, pwm_out});
      check("p9_wrap", read_data);
    end

    // WRAP clear mid-period, then clear coinciding with a wrap (t=30)
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, "wrap_mid_clr", 32'h0);
    while (t < 29) tick();
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, "wrap_set_wins", 32'h1);
    rd(A_COUNT,  "count_val", 32'h1);

    // DUTY0=7 written at COUNT=5: current period keeps 3, next gets 7
    while (t < 35) tick();
    wr(A_DUTY0, 32'd7);
    while (t < 50) begin
      expect_val(pv(0, 0, 0, (t < 40) ? ((t % 10) < 3) : ((t % 10) < 7)));
      check("duty_shadow", {28'h0, pwm_out});
      tick();
    end

    // DUTY2=0 constant low, DUTY3=0xFFFF constant high from next period
    wr(A_DUTY3, 32'h0000_FFFF);
    wr(A_DUTY2, 32'h0);
    while (t < 60) tick();
    while (t < 70) begin
      expect_val(pv(1'b1, 1'b0, 0, (t % 10) < 7));
      check("duty_extremes", {28'h0, pwm_out});
      tick();
    end

    // Disable: counter parked, outputs low, registers kept
    wr(A_CTRL, 32'h0);
    expect_val(32'h0); check("dis_pwm", {28'h0, pwm_out});
    rd(A_COUNT,          "dis_count",      32'h0);
    rd(A_PERIOD,         "period_kept",    32'd9);
    rd(BASE + 32'h40,    "oob_read",       32'h0);
    rd(BASE + 32'h06,    "lowbits_ignored", 32'd9);
    wr(A_COUNT, 32'd5);
    rd(A_COUNT,          "count_ro",       32'h0);
    wr(BASE + 32'h20, 32'h0301);
    rd(A_CTRL,           "nohit_write",    32'h0);
    rd(A_DUTY0,          "duty0_rb",       32'd7);

    // Read-during-write returns the old value
    write_mem     = 1'b1;
    write_address = A_PERIOD;
    write_data    = 32'd5;
    read_address  = A_PERIOD;
    expect_val(32'd9);
    tick();
    write_mem = 1'b0;
    check("rdw_old", read_data);
    rd(A_PERIOD, "rdw_new", 32'd5);

    // PRESC=3, PERIOD=4, DUTY1=2: pwm_out[1] high 8 of every 20 cycles
    wr(A_PERIOD, 32'd4);
    wr(A_DUTY0,  32'h0);
    wr(A_DUTY3,  32'h0);
    wr(A_DUTY1,  32'd2);
    wr(A_CTRL,   32'h0301);
    t = 0;
    while (t < 40) begin
      expect_val(pv(0, 0, (t % 20) < 8, 0));
      check("presc_pwm", {28'h0, pwm_out});
      tick();
    end
    rd(A_CTRL, "ctrl_rb", 32'h0301);
    while (t < 45) tick();
    rd(A_COUNT, "presc_count", 32'h1);

    // Reset mid-run, with a simultaneous CTRL write that must lose
    reset         = 1'b1;
    write_mem     = 1'b1;
    write_address = A_CTRL;
    write_data    = 32'h1;
    tick();
    reset     = 1'b0;
    write_mem = 1'b0;
    expect_val(32'h0); check("rst_mid_pwm", {28'h0, pwm_out});
    expect_val(32'h0); check("rst_mid_rdata", read_data);
    rd(A_COUNT,  "rst_mid_count", 32'h0);
    rd(A_STATUS, "rst_no_wrap",   32'h0);
    rd(A_CTRL,   "rst_over_write", 32'h0);

    // PERIOD=0: COUNT stays 0, every tick wraps, pwm high iff duty != 0
    wr(A_DUTY0, 32'd1);
    wr(A_CTRL,  32'h1);
    for (int i = 0; i < 4; i++) begin
      expect_val(pv(0, 0, 0, 1'b1));
      check("p0_pwm", {28'h0, pwm_out});
      tick();
    end
    rd(A_STATUS, "p0_wrap",  32'h1);
    rd(A_COUNT,  "p0_count", 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
